issue_reg_read: RTL and testbench
=================================

ISSUE_REG_READ -- requirements
Module: issue_reg_read

Interface
REQ-001 The block SHALL have parameter PREG_NUM, default 64, the number of physical registers; PREG_W = $clog2(PREG_NUM).
REQ-002 The block SHALL have parameter DATA_W, default 32, the operand data width.
REQ-003 The block SHALL have parameter PAYLOAD_W, default 64, the opaque issue payload width (op code, rob_idx, dest); it passes through unmodified.
REQ-004 The block SHALL have parameter WB_PORTS, default 2, the number of writeback bypass ports.
REQ-005 The block SHALL have port clk, input, 1 bit: clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port flush_i, input, 1 bit: pipeline flush.
REQ-008 The block SHALL have ports in_valid_i (input, 1) and in_ready_o (output, 1): the issue handshake from the reservation station.
REQ-009 The block SHALL have ports in_src0_valid_i and in_src1_valid_i (input, 1 each): the source is used.
REQ-010 The block SHALL have ports in_psrc0_i and in_psrc1_i (input, PREG_W each): the source physical registers.
REQ-011 The block SHALL have port in_payload_i, input, PAYLOAD_W: the issue payload.
REQ-012 The block SHALL have ports rf_raddr0_o and rf_raddr1_o (output, PREG_W each): register-file read addresses, combinational.
REQ-013 The block SHALL have ports rf_rdata0_i and rf_rdata1_i (input, DATA_W each): synchronous read data, valid the cycle after the address is presented.
REQ-014 The block SHALL have ports wb_valid_i (input, WB_PORTS), wb_preg_i (input, WB_PORTS x PREG_W) and wb_data_i (input, WB_PORTS x DATA_W): writeback ports.
REQ-015 The block SHALL have ports out_valid_o (output, 1) and out_ready_i (input, 1): the handshake to the execution unit.
REQ-016 The block SHALL have ports out_src0_o and out_src1_o (output, DATA_W each): the operands.
REQ-017 The block SHALL have port out_payload_o, output, PAYLOAD_W: the registered payload.

Function
REQ-018 The block SHALL use a single holding stage R1 containing: valid, payload, per-source use flag, bypass-hit flag, bypass data, captured flag, and captured data.
REQ-019 The block SHALL drive in_ready_o = ~r1_valid | out_ready_i, with no dependency on in_valid_i.
REQ-020 The block SHALL drive rf_raddr0_o = in_psrc0_i and rf_raddr1_o = in_psrc1_i every cycle.
REQ-021 An accept SHALL be in_valid_i & in_ready_o; on accept, R1 loads the payload and source flags, r1_valid becomes 1 next cycle, and the captured flags clear.
REQ-022 Latency SHALL be one cycle from accept to out_valid_o, with a throughput of one instruction per cycle under no backpressure.
REQ-023 Bypass at accept: for each used source with psrc != 0, the block SHALL set the bypass-hit flag and store wb_data_i[k] for the lowest k where wb_valid_i[k] & wb_preg_i[k] == psrc, because the RF returns pre-write data on a same-cycle write.
REQ-024 The block SHALL ignore writebacks in any cycle other than the accept cycle.
REQ-025 Operand select, in priority order:
  - source unused or psrc == 0 -> 0;
  - captured -> captured data;
  - bypass hit -> bypass data;
  - otherwise -> rf_rdataN_i.
REQ-026 In the first cycle R1 is valid, if out_ready_i == 0, the block SHALL latch the selected operands into the captured data and set the captured flags, so that a stall never relies on stale RF output.
REQ-027 Outputs SHALL remain stable while out_valid_o & ~out_ready_i.
REQ-028 A handshake with no new accept SHALL clear r1_valid; a simultaneous handshake and accept SHALL reload R1 (back-to-back).
REQ-029 flush_i SHALL clear r1_valid next cycle and take priority over a same-cycle accept; in_ready_o is unaffected by flush.
REQ-030 When out_valid_o == 0, the block SHALL drive out_src0_o, out_src1_o and out_payload_o to 0.

Reset
REQ-031 While rst_n == 0, the block SHALL drive r1_valid, all flags, captured/bypass data and the payload to 0, so that out_valid_o = 0, out_src*_o = 0, out_payload_o = 0 and in_ready_o = 1.
REQ-032 Reset asserted mid-stall SHALL discard the held instruction; the first instruction after deassertion behaves per REQ-021.

Verification
REQ-033 Single issue: accept psrc0=5, psrc1=9; RF returns 0x11/0x22 next cycle; out_ready_i=1 -> out_valid_o=1 one cycle later, out_src0_o=0x11, out_src1_o=0x22, payload matches.
REQ-034 Same-cycle bypass: accept psrc0=7 with wb_valid_i[1]=1, wb_preg_i[1]=7, wb_data_i[1]=0xABCD; RF returns stale 0 -> out_src0_o=0xABCD.
REQ-035 Stall: out_ready_i=0 for 3 cycles; RF data changes to 0xFFFF after the first cycle -> out_src0_o/out_src1_o hold their first-cycle values and in_ready_o=0 throughout; one handshake occurs on release.
REQ-036 Streaming: 8 back-to-back accepts with out_ready_i=1 -> 8 outputs on consecutive cycles, in order, with no bubbles.
REQ-037 Zero/unused sources: psrc0=0 and in_src1_valid_i=0 -> both operands are 0 regardless of RF data.
REQ-038 Flush: flush_i together with an accept while R1 is valid -> out_valid_o=0 next cycle; the flushed instruction is never emitted.

Source files
------------

// File: rtl/issue_reg_read.sv
// Issue-to-execute register-read stage: one holding slot that gathers operands
// from a synchronous RF with same-cycle writeback bypass and stall capture.
module issue_reg_read #(
  parameter int unsigned PREG_NUM  = 64,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PAYLOAD_W = 64,
  parameter int unsigned WB_PORTS  = 2,
  localparam int unsigned PREG_W   = $clog2(PREG_NUM)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic                               in_src0_valid_i,
  input  logic                               in_src1_valid_i,
  input  logic [PREG_W-1:0]                  in_psrc0_i,
  input  logic [PREG_W-1:0]                  in_psrc1_i,
  input  logic [PAYLOAD_W-1:0]               in_payload_i,
  output logic [PREG_W-1:0]                  rf_raddr0_o,
  output logic [PREG_W-1:0]                  rf_raddr1_o,
  input  logic [DATA_W-1:0]                  rf_rdata0_i,
  input  logic [DATA_W-1:0]                  rf_rdata1_i,
  input  logic [WB_PORTS-1:0]                wb_valid_i,
  input  logic [WB_PORTS-1:0][PREG_W-1:0]    wb_preg_i,
  input  logic [WB_PORTS-1:0][DATA_W-1:0]    wb_data_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [DATA_W-1:0]                  out_src0_o,
  output logic [DATA_W-1:0]                  out_src1_o,
  output logic [PAYLOAD_W-1:0]               out_payload_o
);

  localparam int unsigned WB_IW = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;

  logic                 r1_valid,   r1_valid_d;
  logic [PAYLOAD_W-1:0] r1_payload, r1_payload_d;
  logic                 r1_use0,    r1_use0_d,  r1_use1,  r1_use1_d;
  logic                 r1_hit0,    r1_hit0_d,  r1_hit1,  r1_hit1_d;
  logic [DATA_W-1:0]    r1_byp0,    r1_byp0_d,  r1_byp1,  r1_byp1_d;
  logic                 r1_cap,     r1_cap_d;
  logic [DATA_W-1:0]    r1_capd0,   r1_capd0_d, r1_capd1, r1_capd1_d;

  logic                 accept, handshake;
  logic [DATA_W:0]      lk0, lk1;
  logic [DATA_W-1:0]    sel0, sel1;

  // RF reads pre-write data, so an accept-cycle writeback must be caught here;
  // the lowest-numbered matching port wins.
  function automatic logic [DATA_W:0] wb_lookup(input logic [PREG_W-1:0] p,
                                                input logic [WB_PORTS-1:0] v,
                                                input logic [WB_PORTS-1:0][PREG_W-1:0] pr,
                                                input logic [WB_PORTS-1:0][DATA_W-1:0] d);
    logic [DATA_W:0]  r;
    logic [WB_IW-1:0] idx;
    r = '0;
    for (int k = int'(WB_PORTS) - 1; k >= 0; k--) begin
      idx = WB_IW'(k);
      if (v[idx] && (pr[idx] == p)) r = {1'b1, d[idx]};
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] pick(input logic use_src, input logic cap,
                                             input logic hit, input logic [DATA_W-1:0] capd,
                                             input logic [DATA_W-1:0] byp,
                                             input logic [DATA_W-1:0] rd);
    if (!use_src) return '0;
    if (cap)      return capd;
    if (hit)      return byp;
    return rd;
  endfunction

  assign in_ready_o  = ~r1_valid | out_ready_i;
  assign rf_raddr0_o = in_psrc0_i;
  assign rf_raddr1_o = in_psrc1_i;
  assign accept      = in_valid_i & in_ready_o;
  assign handshake   = r1_valid & out_ready_i;

  always_comb begin
    lk0  = wb_lookup(in_psrc0_i, wb_valid_i, wb_preg_i, wb_data_i);
    lk1  = wb_lookup(in_psrc1_i, wb_valid_i, wb_preg_i, wb_data_i);
    sel0 = pick(r1_use0, r1_cap, r1_hit0, r1_capd0, r1_byp0, rf_rdata0_i);
    sel1 = pick(r1_use1, r1_cap, r1_hit1, r1_capd1, r1_byp1, rf_rdata1_i);
  end

  // Next-state for the holding slot: flush > accept > drain > first-cycle capture.
  always_comb begin
    r1_valid_d   = r1_valid;
    r1_payload_d = r1_payload;
    r1_use0_d    = r1_use0;
    r1_use1_d    = r1_use1;
    r1_hit0_d    = r1_hit0;
    r1_hit1_d    = r1_hit1;
    r1_byp0_d    = r1_byp0;
    r1_byp1_d    = r1_byp1;
    r1_cap_d     = r1_cap;
    r1_capd0_d   = r1_capd0;
    r1_capd1_d   = r1_capd1;
    if (flush_i) begin
      r1_valid_d = 1'b0;
    end else if (accept) begin
      r1_valid_d   = 1'b1;
      r1_payload_d = in_payload_i;
      r1_use0_d    = in_src0_valid_i & (in_psrc0_i != '0);
      r1_use1_d    = in_src1_valid_i & (in_psrc1_i != '0);
      r1_hit0_d    = r1_use0_d & lk0[DATA_W];
      r1_hit1_d    = r1_use1_d & lk1[DATA_W];
      r1_byp0_d    = lk0[DATA_W-1:0];
      r1_byp1_d    = lk1[DATA_W-1:0];
      r1_cap_d     = 1'b0;
    end else if (handshake) begin
      r1_valid_d = 1'b0;
    end else if (r1_valid && !r1_cap) begin
      r1_cap_d   = 1'b1;
      r1_capd0_d = sel0;
      r1_capd1_d = sel1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid   <= 1'b0;
      r1_payload <= '0;
      r1_use0    <= 1'b0;
      r1_use1    <= 1'b0;
      r1_hit0    <= 1'b0;
      r1_hit1    <= 1'b0;
      r1_byp0    <= '0;
      r1_byp1    <= '0;
      r1_cap     <= 1'b0;
      r1_capd0   <= '0;
      r1_capd1   <= '0;
    end else begin
      r1_valid   <= r1_valid_d;
      r1_payload <= r1_payload_d;
      r1_use0    <= r1_use0_d;
      r1_use1    <= r1_use1_d;
      r1_hit0    <= r1_hit0_d;
      r1_hit1    <= r1_hit1_d;
      r1_byp0    <= r1_byp0_d;
      r1_byp1    <= r1_byp1_d;
      r1_cap     <= r1_cap_d;
      r1_capd0   <= r1_capd0_d;
      r1_capd1   <= r1_capd1_d;
    end
  end

  assign out_valid_o   = r1_valid;
  assign out_src0_o    = r1_valid ? sel0 : '0;
  assign out_src1_o    = r1_valid ? sel1 : '0;
  assign out_payload_o = r1_valid ? r1_payload : '0;

endmodule

// File: tb/tb_issue_reg_read.sv
// Bench for issue_reg_read: directed vector table, stall/flush/reset sequences,
// and random traffic against an architectural register-value model.
module tb_issue_reg_read;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush, in_valid, in_ready, s0v, s1v;
  logic [5:0]        p0, p1, raddr0, raddr1;
  logic [63:0]       payload, opl;
  logic [31:0]       rd0, rd1, os0, os1;
  logic [1:0]        wbv;
  logic [1:0][5:0]   wbp;
  logic [1:0][31:0]  wbd;
  logic              out_valid, out_ready;

  logic              use_model;
  logic [31:0]       dir_rd0, dir_rd1, mrd0, mrd1;
  logic [31:0]       mem [64];

  int n_cmp = 0;
  int n_err = 0;
  int dut_hs = 0;

  typedef struct {
    logic [63:0] pl;
    logic [31:0] e0, e1;
  } exp_t;
  exp_t q[$];

  typedef struct {
    logic s0v, s1v;
    logic [5:0] p0, p1;
    logic [1:0] wbv;
    logic [5:0] wp0, wp1;
    logic [31:0] wd0, wd1, r0, r1, e0, e1;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  issue_reg_read dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_src0_valid_i(s0v), .in_src1_valid_i(s1v),
    .in_psrc0_i(p0), .in_psrc1_i(p1), .in_payload_i(payload),
    .rf_raddr0_o(raddr0), .rf_raddr1_o(raddr1),
    .rf_rdata0_i(rd0), .rf_rdata1_i(rd1),
    .wb_valid_i(wbv), .wb_preg_i(wbp), .wb_data_i(wbd),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_src0_o(os0), .out_src1_o(os1), .out_payload_o(opl)
  );

  // Synchronous RF: returns pre-write data; port 0 wins a same-register write.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h9E37_79B1;
      mrd0 <= '0;
      mrd1 <= '0;
    end else begin
      mrd0 <= mem[raddr0];
      mrd1 <= mem[raddr1];
      for (int k = 1; k >= 0; k--) if (wbv[k]) mem[wbp[k]] <= wbd[k];
    end
  end

  assign rd0 = use_model ? mrd0 : dir_rd0;
  assign rd1 = use_model ? mrd1 : dir_rd1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Value register p holds once this cycle's writebacks land.
  function automatic logic [31:0] arch_val(input logic v, input logic [5:0] p);
    logic [31:0] r;
    if (!v || p == 6'd0) return 32'd0;
    r = mem[p];
    for (int k = 1; k >= 0; k--) if (wbv[k] && wbp[k] == p) r = wbd[k];
    return r;
  endfunction

  // Called at a negedge with stimulus set; checks, advances model, moves to next negedge.
  task automatic step();
    logic ev, er, acc, hs;
    exp_t e;
    #1;
    ev = (q.size() != 0);
    er = !ev || out_ready;
    chk("raddr0", 64'(raddr0), 64'(p0));
    chk("raddr1", 64'(raddr1), 64'(p1));
    chk("in_ready", 64'(in_ready), 64'(er));
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (ev) begin
      chk("src0", 64'(os0), 64'(q[0].e0));
      chk("src1", 64'(os1), 64'(q[0].e1));
      chk("payload", opl, q[0].pl);
    end else begin
      chk("idle_out", {os0, os1} | opl, 64'd0);
    end
    if (out_valid && out_ready) dut_hs++;
    acc = in_valid && er;
    hs  = ev && out_ready;
    e.pl = payload;
    e.e0 = arch_val(s0v, p0);
    e.e1 = arch_val(s1v, p1);
    if (hs) void'(q.pop_front());
    if (flush) q.delete();
    else if (acc) q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_stim();
    flush    = ($urandom % 20) == 0;
    in_valid = ($urandom % 10) < 7;
    out_ready = ($urandom % 10) < 6;
    s0v = ($urandom % 8) != 0;
    s1v = ($urandom % 8) != 0;
    p0  = 6'($urandom_range(0, 7));
    p1  = 6'($urandom_range(0, 7));
    payload = {$urandom, $urandom};
    wbv = 2'($urandom);
    for (int k = 0; k < 2; k++) begin
      wbp[k] = 6'($urandom_range(0, 7));
      wbd[k] = $urandom;
    end
  endtask

  initial begin
    int hs0;
    rst_n = 1'b0; use_model = 1'b0; flush = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0; s0v = 1'b1; s1v = 1'b1;
    p0 = 6'd3; p1 = 6'd4; payload = 64'hDEAD_BEEF_0000_0001;
    wbv = '0; wbp = '0; wbd = '0; dir_rd0 = 32'h1234; dir_rd1 = 32'h5678;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outs", {os0, os1} | opl, 64'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // s0v s1v p0 p1 wbv wp0 wp1 wd0 wd1 rd0 rd1 exp0 exp1
    tbl[0] = '{1'b1, 1'b1, 6'd5, 6'd9, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 32'h11, 32'h22, 32'h11, 32'h22};
    tbl[1] = '{1'b1, 1'b1, 6'd7, 6'd3, 2'b10, 6'd0, 6'd7, 32'h0, 32'hABCD, 32'h0, 32'h33, 32'hABCD, 32'h33};
    tbl[2] = '{1'b1, 1'b0, 6'd0, 6'd4, 2'b00, 6'd0, 6'd0, 32'h0, 32'h0, 32'hDEAD, 32'hBEEF, 32'h0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 6'd6, 6'd6, 2'b11, 6'd6, 6'd6, 32'h1111, 32'h2222, 32'h0, 32'h0, 32'h1111, 32'h1111};
    tbl[4] = '{1'b1, 1'b1, 6'd0, 6'd2, 2'b01, 6'd0, 6'd0, 32'h5555, 32'h0, 32'h77, 32'h88, 32'h0, 32'h88};
    tbl[5] = '{1'b1, 1'b0, 6'd1, 6'd8, 2'b10, 6'd0, 6'd8, 32'h0, 32'h9999, 32'h44, 32'h66, 32'h44, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 6'd5, 6'd5, 2'b00, 6'd5, 6'd5, 32'hAAAA, 32'hBBBB, 32'h12, 32'h12, 32'h12, 32'h12};

    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      s0v = tbl[i].s0v; s1v = tbl[i].s1v; p0 = tbl[i].p0; p1 = tbl[i].p1;
      payload = 64'hA000 + 64'(i);
      wbv = tbl[i].wbv; wbp[0] = tbl[i].wp0; wbp[1] = tbl[i].wp1;
      wbd[0] = tbl[i].wd0; wbd[1] = tbl[i].wd1;
      #1 chk("vec_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; wbv = '0;
      dir_rd0 = tbl[i].r0; dir_rd1 = tbl[i].r1;
      #1;
      chk("vec_valid", 64'(out_valid), 64'd1);
      chk("vec_src0", 64'(os0), 64'(tbl[i].e0));
      chk("vec_src1", 64'(os1), 64'(tbl[i].e1));
      chk("vec_payload", opl, 64'hA000 + 64'(i));
      @(posedge clk); @(negedge clk);
      #1 chk("vec_drained", 64'(out_valid), 64'd0);
    end

    // Stall with RF data changing underneath; later offers must be refused.
    in_valid = 1'b1; out_ready = 1'b0; s0v = 1'b1; s1v = 1'b1;
    p0 = 6'd5; p1 = 6'd9; payload = 64'h5555_0001; wbv = '0;
    @(posedge clk); @(negedge clk);
    payload = 64'h6666_0002; dir_rd0 = 32'h11; dir_rd1 = 32'h22;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_src0", 64'(os0), 64'h11);
      chk("stall_src1", 64'(os1), 64'h22);
      chk("stall_payload", opl, 64'h5555_0001);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); @(negedge clk);
      dir_rd0 = 32'hFFFF; dir_rd1 = 32'hFFFF;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    chk("release_src0", 64'(os0), 64'h11);
    chk("release_src1", 64'(os1), 64'h22);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); @(negedge clk);
    #1 chk("release_once", 64'(out_valid), 64'd0);
    @(negedge clk);

    // Model-driven phases.
    use_model = 1'b1;
    wbv = '0; flush = 1'b0;

    // Streaming: 8 back-to-back accepts.
    hs0 = dut_hs;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; s0v = 1'b1; s1v = 1'b1;
      p0 = 6'(i + 1); p1 = 6'(i + 10); payload = 64'hB000 + 64'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("stream_count", 64'(dut_hs - hs0), 64'd8);

    // Flush with accept while R1 holds an instruction (both ready and stalled).
    for (int r = 0; r < 2; r++) begin
      in_valid = 1'b1; out_ready = 1'b0; p0 = 6'd2; p1 = 6'd3; payload = 64'hC000 + 64'(r);
      step();
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'(r); payload = 64'hD000 + 64'(r);
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1 chk("flush_gone", 64'(out_valid), 64'd0);
      step();
    end

    // Reset during a stall discards the held instruction.
    in_valid = 1'b1; out_ready = 1'b0; payload = 64'hE000;
    step();
    in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_outs", {os0, os1} | opl, 64'd0);
    q.delete();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1; p0 = 6'd4; p1 = 6'd0; payload = 64'hE001;
    step();
    in_valid = 1'b0;
    step();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rand_stim();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
